// File: rtl/riscv_v_uop_sequencer_if.sv
// rtl/riscv_v_uop_sequencer_if.sv - decode-side instruction and execute-side uop channels of the vector uop sequencer
interface riscv_v_uop_sequencer_if #(
    parameter int VREG_W = 5,
    parameter int VL_W   = 8
);
    logic              clear_pipe;
    logic              instr_valid;
    logic              instr_ready;
    logic [VREG_W-1:0] instr_vd;
    logic [VREG_W-1:0] instr_vs1;
    logic [VREG_W-1:0] instr_vs2;
    logic [2:0]        vsew;
    logic [2:0]        vlmul;
    logic [VL_W-1:0]   vl;
    logic [VL_W-1:0]   vstart;
    logic              uop_valid;
    logic              uop_ready;
    logic [VREG_W-1:0] uop_vd;
    logic [VREG_W-1:0] uop_vs1;
    logic [VREG_W-1:0] uop_vs2;
    logic [2:0]        uop_idx;
    logic [VL_W-1:0]   uop_elem_start;
    logic [VL_W-1:0]   uop_elem_cnt;
    logic              uop_last;
    logic              done;
    logic              illegal;
    logic              busy;

    modport master (
        input  clear_pipe, instr_valid, instr_vd, instr_vs1, instr_vs2,
               vsew, vlmul, vl, vstart, uop_ready,
        output instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx,
               uop_elem_start, uop_elem_cnt, uop_last, done, illegal, busy
    );

    modport slave (
        output clear_pipe, instr_valid, instr_vd, instr_vs1, instr_vs2,
               vsew, vlmul, vl, vstart, uop_ready,
        input  instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx,
               uop_elem_start, uop_elem_cnt, uop_last, done, illegal, busy
    );
endinterface

// File: rtl/riscv_v_uop_sequencer.sv
// rtl/riscv_v_uop_sequencer.sv - strip-mines one vector instruction into per-register uops over its LMUL group
module riscv_v_uop_sequencer #(
    parameter int VLEN   = 128,
    parameter int ELEN   = 32,
    parameter int VREG_W = 5,
    parameter int VL_W   = $clog2(VLEN) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    riscv_v_uop_sequencer_if.master    bus
);
    localparam int LOG_VLEN = $clog2(VLEN);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_ILL} state_t;

    state_t            state, state_nx;
    logic [VREG_W-1:0] l_vd, l_vs1, l_vs2;
    logic [VL_W-1:0]   l_vstart, l_vle;
    logic [4:0]        l_log;
    logic [2:0]        idx, first_idx, last_idx;

    // Decode of the offered instruction; only meaningful in the accept cycle.
    logic        in_illegal, in_empty;
    logic [4:0]  in_log;
    logic [31:0] in_epr, in_vlmax, in_vle, in_vl, in_vstart;
    logic [1:0]  lmul_sh;

    always_comb begin
        in_vl      = 32'(bus.vl);
        in_vstart  = 32'(bus.vstart);
        lmul_sh    = bus.vlmul[2] ? 2'd0 : bus.vlmul[1:0];
        in_illegal = bus.vsew[2] || (bus.vlmul == 3'd4) || ((32'd8 << bus.vsew) > 32'(ELEN));
        in_log     = 5'(LOG_VLEN - 3) - {3'b000, bus.vsew[1:0]};
        in_epr     = 32'd1 << in_log;
        in_vlmax   = in_epr << lmul_sh;
        in_vle     = (in_vl < in_vlmax) ? in_vl : in_vlmax;
        in_empty   = in_vstart >= in_vle;
    end

    wire accept    = (state == S_IDLE) && bus.instr_valid && !bus.clear_pipe;
    wire handshake = (state == S_ISSUE) && bus.uop_ready;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.instr_valid)
                         state_nx = in_illegal ? S_ILL : (in_empty ? S_DONE : S_ISSUE);
            S_ISSUE: if (bus.uop_ready && idx == last_idx) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
        if (bus.clear_pipe) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            l_vd      <= '0;
            l_vs1     <= '0;
            l_vs2     <= '0;
            l_vstart  <= '0;
            l_vle     <= '0;
            l_log     <= '0;
            idx       <= '0;
            first_idx <= '0;
            last_idx  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                l_vd      <= bus.instr_vd;
                l_vs1     <= bus.instr_vs1;
                l_vs2     <= bus.instr_vs2;
                l_vstart  <= bus.vstart;
                l_vle     <= VL_W'(in_vle);
                l_log     <= in_log;
                idx       <= 3'(in_vstart >> in_log);
                first_idx <= 3'(in_vstart >> in_log);
                last_idx  <= 3'((in_vle - 32'd1) >> in_log);
            end else if (handshake && !bus.clear_pipe) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Element window of the current register, derived from the latched instruction.
    logic [31:0] epr, reg_base, remain, hi, estart;
    always_comb begin
        epr      = 32'd1 << l_log;
        reg_base = 32'(idx) << l_log;
        remain   = 32'(l_vle) - reg_base;
        hi       = (remain < epr) ? remain : epr;
        estart   = (idx == first_idx) ? (32'(l_vstart) & (epr - 32'd1)) : 32'd0;
    end

    wire issuing = (state == S_ISSUE);

    assign bus.instr_ready    = (state == S_IDLE);
    assign bus.busy           = (state != S_IDLE);
    assign bus.done           = (state == S_DONE);
    assign bus.illegal        = (state == S_ILL);
    assign bus.uop_valid      = issuing;
    assign bus.uop_vd         = issuing ? l_vd  + VREG_W'(idx) : '0;
    assign bus.uop_vs1        = issuing ? l_vs1 + VREG_W'(idx) : '0;
    assign bus.uop_vs2        = issuing ? l_vs2 + VREG_W'(idx) : '0;
    assign bus.uop_idx        = issuing ? idx : 3'd0;
    assign bus.uop_elem_start = issuing ? VL_W'(estart) : '0;
    assign bus.uop_elem_cnt   = issuing ? VL_W'(hi - estart) : '0;
    assign bus.uop_last       = issuing && (idx == last_idx);
endmodule
